// File: rtl/bcd_seg7_scanner_pkg.sv
// rtl/bcd_seg7_scanner_pkg.sv - glyph constants, scanner states and timing defaults
package bcd_seg7_scanner_pkg;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG7_0 = 7'h3F;
    localparam logic [6:0] SEG7_1 = 7'h06;
    localparam logic [6:0] SEG7_2 = 7'h5B;
    localparam logic [6:0] SEG7_3 = 7'h4F;
    localparam logic [6:0] SEG7_4 = 7'h66;
    localparam logic [6:0] SEG7_5 = 7'h6D;
    localparam logic [6:0] SEG7_6 = 7'h7D;
    localparam logic [6:0] SEG7_7 = 7'h07;
    localparam logic [6:0] SEG7_8 = 7'h7F;
    localparam logic [6:0] SEG7_9 = 7'h6F;
    localparam logic [6:0] SEG7_E = 7'h79;

    localparam int DEF_DIGIT_CYCLES = 16;
    localparam int DEF_GAP_CYCLES   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_LO,
        ST_GAP_A,
        ST_SCAN_HI,
        ST_GAP_B
    } scan_state_e;

endpackage

// File: rtl/bcd_seg7_scanner_decode.sv
// rtl/bcd_seg7_scanner_decode.sv - combinational BCD nibble to 7-segment glyph
module bcd_seg7_decode
    import bcd_seg7_scanner_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG7_E;
        case (nibble_i)
            4'd0:    glyph_o = SEG7_0;
            4'd1:    glyph_o = SEG7_1;
            4'd2:    glyph_o = SEG7_2;
            4'd3:    glyph_o = SEG7_3;
            4'd4:    glyph_o = SEG7_4;
            4'd5:    glyph_o = SEG7_5;
            4'd6:    glyph_o = SEG7_6;
            4'd7:    glyph_o = SEG7_7;
            4'd8:    glyph_o = SEG7_8;
            4'd9:    glyph_o = SEG7_9;
            default: glyph_o = SEG7_E;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// rtl/bcd_seg7_scanner.sv - 2-digit multiplexed 7-segment scanner with frame-aligned commit
module bcd_seg7_scanner
    import bcd_seg7_scanner_pkg::*;
#(
    parameter int DIGIT_CYCLES   = DEF_DIGIT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bcd_in,
    input  logic       bcd_valid,
    output logic       bcd_ready,
    input  logic       blank_leading,
    output logic [6:0] seg,
    output logic [1:0] dig_en
);

    localparam int MAXC = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DIG_LOAD = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    scan_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    pend_q;
    logic          pend_bl_q;
    logic          pend_full_q;
    logic [7:0]    disp_q;
    logic          disp_bl_q;
    logic [6:0]    seg_q;
    logic [1:0]    dig_q;

    logic       xfer;
    logic       cnt_done;
    logic       commit;
    logic       hi_blank;
    logic [3:0] nibble_sel;
    logic [6:0] glyph;

    assign bcd_ready = !pend_full_q;
    assign xfer      = bcd_valid && bcd_ready;
    assign cnt_done  = (cnt_q == '0);
    // Pending only lands in the display when idle or at the end of a full frame
    assign commit    = pend_full_q &&
                       ((state_q == ST_IDLE) || ((state_q == ST_GAP_B) && cnt_done));
    assign hi_blank  = disp_bl_q && (disp_q[7:4] == 4'd0);
    assign nibble_sel = (state_q == ST_SCAN_HI) ? disp_q[7:4] : disp_q[3:0];

    bcd_seg7_decode u_decode (
        .nibble_i (nibble_sel),
        .glyph_o  (glyph)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_bl_q   <= 1'b0;
            pend_full_q <= 1'b0;
            disp_q      <= '0;
            disp_bl_q   <= 1'b0;
            seg_q       <= '0;
            dig_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_full_q) begin
                        state_q <= ST_SCAN_LO;
                        cnt_q   <= DIG_LOAD;
                    end
                end
                ST_SCAN_LO: begin
                    if (cnt_done) begin
                        state_q <= ST_GAP_A;
                        cnt_q   <= GAP_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_GAP_A: begin
                    if (cnt_done) begin
                        state_q <= ST_SCAN_HI;
                        cnt_q   <= DIG_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_SCAN_HI: begin
                    if (cnt_done) begin
                        state_q <= ST_GAP_B;
                        cnt_q   <= GAP_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_GAP_B: begin
                    if (cnt_done) begin
                        state_q <= ST_SCAN_LO;
                        cnt_q   <= DIG_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase

            if (commit) begin
                disp_q    <= pend_q;
                disp_bl_q <= pend_bl_q;
            end

            if (xfer) begin
                pend_q      <= bcd_in;
                pend_bl_q   <= blank_leading;
                pend_full_q <= 1'b1;
            end else if (commit) begin
                pend_full_q <= 1'b0;
            end

            case (state_q)
                ST_SCAN_LO: begin
                    dig_q <= 2'b01;
                    seg_q <= glyph;
                end
                ST_SCAN_HI: begin
                    dig_q <= hi_blank ? 2'b00 : 2'b10;
                    seg_q <= hi_blank ? 7'h00 : glyph;
                end
                default: begin
                    dig_q <= 2'b00;
                    seg_q <= 7'h00;
                end
            endcase
        end
    end

    assign seg    = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dig_en = DIG_ACTIVE_LOW ? ~dig_q : dig_q;

endmodule
